dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline memory-access stage (port P) and the UART/program loader (port L).
- Sequences each transaction through issue, latency-wait and response phases, and drives the stall the pipeline sees while its access is pending.
- Fixed priority to P, with a starvation guard for L.
- Sits between the memory-access stage / loader and the data_memory instance.

Parameters:
- DATA_MEM_WIDTH, 3, log2 of data memory depth in 32-bit words.
- MEM_LATENCY, 1, cycles from mem strobe to valid mem_rdata (legal range 1..15).
- STARVE_LIMIT, 4, consecutive P-won contested arbitrations before L is forced (1..15).

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- p_req  in  1  P request; held with p_we/p_addr/p_wdata until p_ack
- p_we  in  1  1=write, 0=read
- p_addr  in  32  P byte address
- p_wdata  in  32  P write data
- p_ack  out  1  one-cycle completion pulse to P
- p_rdata  out  32  P read data, valid while p_ack
- l_req, l_we, l_addr, l_wdata, l_ack, l_rdata  same as P set, for L
- err  out  1  pulses with ack when the completed access was out of range or misaligned
- stall  out  1  combinational: p_req & ~p_ack
- mem_addr  out  DATA_MEM_WIDTH  word index to memory
- mem_wdata  out  32  write data to memory
- mem_we  out  1  write strobe, one cycle
- mem_re  out  1  read strobe, one cycle
- mem_rdata  in  32  memory read data
- perf_stall_cnt  out  32  see Optional Feature
- perf_lgrant_cnt  out  32  see Optional Feature

Behaviour:
- Reset (async, immediate):
  - state=IDLE, all acks/err/strobes=0, rdata=0, starve_cnt=0, grant=P.
  - Reset mid-transaction drops the transaction: no ack, no strobe.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered except stall.
- IDLE:
  - If any req, arbitrate and latch grant, we, addr and wdata; go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only P requesting: grant P.
  - Only L requesting: grant L; starve_cnt=0.
  - Both requesting and starve_cnt==STARVE_LIMIT: grant L; starve_cnt=0.
  - Both requesting otherwise: grant P; starve_cnt+=1.
- Legality check on the latched address:
  - Illegal if addr[1:0]!=0, or if any addr bit above DATA_MEM_WIDTH+1 is 1.
  - mem_addr = addr[DATA_MEM_WIDTH+1:2].
- ISSUE (1 cycle):
  - Legal access: assert mem_we or mem_re.
  - Illegal access: no strobe.
  - Legal read: load cnt=MEM_LATENCY, go to WAIT.
  - Write or illegal access: go to DONE.
- WAIT:
  - cnt decrements each cycle.
  - At cnt==1, capture mem_rdata into the granted port's rdata, then go to DONE.
- DONE (1 cycle):
  - Pulse ack of the granted port; pulse err if the access was illegal.
  - Illegal read returns rdata=0.
  - Go to IDLE. Re-arbitration happens in the following IDLE cycle (one idle bubble between transactions).
- Latency, counting req sampled in IDLE as cycle 0:
  - Legal read acks at cycle 2+MEM_LATENCY.
  - Write or illegal access acks at cycle 2.
- rdata holds its last captured value until the next read to that port.
- Requester dropping req before ack: protocol violation. The transaction still completes and acks.
- A req arriving while busy waits; it is not lost.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt increments every cycle stall==1.
  - perf_lgrant_cnt increments on every L grant.
  - Both 32-bit, wrap at 2^32, cleared by reset.
- Undefined: both outputs are constant 0 and no counter flops are inferred.

Test Plan:
- P read, addr=0x8, mem word 2 = 0xDEADBEEF, MEM_LATENCY=1 -> mem_re at cycle 1 with mem_addr=2; p_ack and p_rdata=0xDEADBEEF at cycle 3; stall high cycles 0-2.
- L write, addr=0x4, wdata=0x12345678 -> mem_we at cycle 1 with mem_addr=1; l_ack at cycle 2; a following P read of 0x4 returns 0x12345678.
- P and L both requesting continuously, STARVE_LIMIT=4 -> grant order P,P,P,P,L,P,P,P,P,L; perf_lgrant_cnt=2 after ten transactions (macro defined).
- P read addr=0x20 (out of range, DATA_MEM_WIDTH=3), then addr=0x6 (misaligned) -> no mem strobe; p_ack and err at cycle 2; p_rdata=0.
- Reset asserted while in WAIT of an L read -> outputs 0 immediately; no l_ack; after release, a held l_req re-arbitrates and completes normally.
- MEM_LATENCY=3, P read -> p_ack at cycle 5, data captured at end of cycle 4.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline memory stage (P) and the loader (L).
// Define DMEM_ARB_PERF_EN to build the stall / L-grant performance counters.
module dmem_arbiter #(
    parameter int DATA_MEM_WIDTH = 3,
    parameter int MEM_LATENCY    = 1,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      p_req,
    input  logic                      p_we,
    input  logic [31:0]               p_addr,
    input  logic [31:0]               p_wdata,
    output logic                      p_ack,
    output logic [31:0]               p_rdata,
    input  logic                      l_req,
    input  logic                      l_we,
    input  logic [31:0]               l_addr,
    input  logic [31:0]               l_wdata,
    output logic                      l_ack,
    output logic [31:0]               l_rdata,
    output logic                      err,
    output logic                      stall,
    output logic [DATA_MEM_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [31:0]               mem_rdata,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_lgrant_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] LAT_INIT  = 4'(MEM_LATENCY);
    localparam logic [3:0] STARVE_MX = 4'(STARVE_LIMIT);

    logic [1:0]  state;
    logic        grant_l;
    logic        we_q;
    logic        illegal_q;
    logic [3:0]  cnt;
    logic [3:0]  starve_cnt;

    logic        both_req;
    logic        pick_l;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic        sel_illegal;

    // Misaligned, or any bit set above the word-index field of a memory byte address.
    function automatic logic addr_illegal(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DATA_MEM_WIDTH + 2)) != 32'd0);
    endfunction

    // L wins when alone, or when P has already won STARVE_LIMIT contested rounds in a row.
    always_comb begin
        both_req    = p_req & l_req;
        pick_l      = l_req & (~p_req | (starve_cnt == STARVE_MX));
        sel_we      = pick_l ? l_we : p_we;
        sel_addr    = pick_l ? l_addr : p_addr;
        sel_illegal = addr_illegal(sel_addr);
    end

    assign stall = p_req & ~p_ack;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_l    <= 1'b0;
            we_q       <= 1'b0;
            illegal_q  <= 1'b0;
            cnt        <= '0;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            p_ack      <= 1'b0;
            l_ack      <= 1'b0;
            err        <= 1'b0;
            p_rdata    <= '0;
            l_rdata    <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            p_ack  <= 1'b0;
            l_ack  <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (p_req | l_req) begin
                        grant_l   <= pick_l;
                        we_q      <= sel_we;
                        illegal_q <= sel_illegal;
                        mem_addr  <= sel_addr[DATA_MEM_WIDTH+1:2];
                        mem_wdata <= pick_l ? l_wdata : p_wdata;
                        // Strobe is registered here so it is visible during ISSUE.
                        mem_re    <= ~sel_illegal & ~sel_we;
                        mem_we    <= ~sel_illegal & sel_we;
                        if (both_req)
                            starve_cnt <= pick_l ? 4'd0 : starve_cnt + 4'd1;
                        else if (l_req)
                            starve_cnt <= 4'd0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (~illegal_q & ~we_q) begin
                        cnt   <= LAT_INIT;
                        state <= WAIT;
                    end else begin
                        p_ack <= ~grant_l;
                        l_ack <= grant_l;
                        err   <= illegal_q;
                        if (illegal_q & ~we_q) begin
                            if (grant_l) l_rdata <= '0;
                            else         p_rdata <= '0;
                        end
                        state <= DONE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        if (grant_l) l_rdata <= mem_rdata;
                        else         p_rdata <= mem_rdata;
                        p_ack <= ~grant_l;
                        l_ack <= grant_l;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            perf_stall_cnt  <= '0;
            perf_lgrant_cnt <= '0;
        end else begin
            if (stall)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((state == IDLE) && pick_l)
                perf_lgrant_cnt <= perf_lgrant_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt  = '0;
    assign perf_lgrant_cnt = '0;
`endif

endmodule
